prog_loader: RTL and testbench

//  Boot-time program loader upstream of the CPU core. Receives a byte stream

---
 rtl/loader_pkg.sv | 39 +++
 rtl/prog_loader_if.sv | 30 +++
 rtl/ldr_timeout.sv | 36 +++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DEPTH_DEF   = 256;
    localparam int unsigned TIMEOUT_DEF = 1000;

    localparam logic HOLD_ACTIVE = 1'b1;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHK,
        DONE,
        ERROR
    } loader_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pm_wr_t;

    // States in which the loader offers rx_ready.
    function automatic logic accepts_byte(input loader_state_e s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == CHK);
    endfunction

    // States in which a stalled sender is timed out (frame already started).
    function automatic logic idle_timed(input loader_state_e s);
        return (s == HDR_LO) || (s == DATA_HI) || (s == DATA_LO) || (s == CHK);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, program-memory write port and status of the loader.
interface prog_loader_if;
    import loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              pm_wr_en;
    logic [ADDR_W-1:0] pm_wr_addr;
    logic [DATA_W-1:0] pm_wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] words_loaded;

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, pm_wr_en, pm_wr_addr, pm_wr_data,
               cpu_hold, done, error, words_loaded
    );

    // Byte source / observer side.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, pm_wr_en, pm_wr_addr, pm_wr_data,
               cpu_hold, done, error, words_loaded
    );

endinterface

// File: rtl/ldr_timeout.sv
// Idle-cycle counter; flags the cycle in which the idle count reaches TIMEOUT.
module ldr_timeout #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires on the idle edge that would take the count to TIMEOUT.
    assign expired_o_c = en_i & ~clr_i & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes program
// memory and releases the core only after the XOR checksum matches.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);

    loader_state_e     state_q, state_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] words_q, words_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] xor_q, xor_d;
    pm_wr_t            wr_q, wr_d;
    logic              rx_ready_q, rx_ready_d;
    logic              pm_wr_en_q, pm_wr_en_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer_c;
    logic              tmo_active_c;
    logic              tmo_expired_c;
    logic [DATA_W-1:0] hdr_count_c;

    assign xfer_c       = bus.rx_valid & rx_ready_q;
    assign tmo_active_c = idle_timed(state_q);
    assign hdr_count_c  = {hi_q, bus.rx_data};

    ldr_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (~tmo_active_c | xfer_c),
        .en_i        (tmo_active_c & ~xfer_c),
        .expired_o_c (tmo_expired_c)
    );

    // Next state, datapath latches and registered-output next values.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        hi_d    = hi_q;
        xor_d   = xor_q;
        wr_d    = wr_q;

        unique case (state_q)
            HDR_HI: begin
                if (xfer_c) begin
                    hi_d    = bus.rx_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer_c) begin
                    count_d = hdr_count_c;
                    xor_d   = '0;
                    if ({1'b0, hdr_count_c} > 17'(DEPTH)) begin
                        state_d = ERROR;
                    end else if (hdr_count_c == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end else if (tmo_expired_c) begin
                    state_d = ERROR;
                end
            end
            DATA_HI: begin
                if (xfer_c) begin
                    hi_d    = bus.rx_data;
                    xor_d   = xor_q ^ bus.rx_data;
                    state_d = DATA_LO;
                end else if (tmo_expired_c) begin
                    state_d = ERROR;
                end
            end
            DATA_LO: begin
                if (xfer_c) begin
                    wr_d.addr = {words_q[DATA_W-2:0], 1'b0};
                    wr_d.data = {hi_q, bus.rx_data};
                    xor_d     = xor_q ^ bus.rx_data;
                    state_d   = WRITE;
                end else if (tmo_expired_c) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                words_d = words_q + 16'd1;
                state_d = (words_d == count_q) ? CHK : DATA_HI;
            end
            CHK: begin
                if (xfer_c) begin
                    state_d = (bus.rx_data == xor_q) ? DONE : ERROR;
                end else if (tmo_expired_c) begin
                    state_d = ERROR;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        rx_ready_d = accepts_byte(state_d);
        pm_wr_en_d = (state_d == WRITE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
        cpu_hold_d = (state_d == DONE) ? ~HOLD_ACTIVE : HOLD_ACTIVE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HDR_HI;
            count_q    <= '0;
            words_q    <= '0;
            hi_q       <= '0;
            xor_q      <= '0;
            wr_q       <= '0;
            rx_ready_q <= 1'b0;
            pm_wr_en_q <= 1'b0;
            cpu_hold_q <= HOLD_ACTIVE;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            hi_q       <= hi_d;
            xor_q      <= xor_d;
            wr_q       <= wr_d;
            rx_ready_q <= rx_ready_d;
            pm_wr_en_q <= pm_wr_en_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.pm_wr_en     = pm_wr_en_q;
    assign bus.pm_wr_addr   = wr_q.addr;
    assign bus.pm_wr_data   = wr_q.data;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_prog_loader;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned TIMEOUT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_loader_if bus ();

    prog_loader #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  byte_q[$];
    logic [31:0] wr_log[$];

    // Reference model: position of the next byte in the frame plus sticky flags.
    bit          m_live, m_done, m_err, m_wr;
    int          m_pos, m_n, m_wl, m_idle;
    logic [7:0]  m_hdr, m_hi, m_x;
    logic [15:0] m_addr, m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function void model_clear();
        m_live = 0; m_done = 0; m_err = 0; m_wr = 0;
        m_pos = 0; m_n = 0; m_wl = 0; m_idle = 0;
        m_hdr = '0; m_hi = '0; m_x = '0; m_addr = '0; m_data = '0;
    endfunction

    function void model_step();
        logic [7:0] b;
        bit         rdy;
        int         k;
        rdy = m_live && !(m_done || m_err || m_wr);
        b   = bus.rx_data;
        m_live = 1;
        if (m_done || m_err) return;
        if (m_wr) begin
            m_wr = 0;
            m_wl++;
            return;
        end
        if (bus.rx_valid && rdy) begin
            m_idle = 0;
            if (m_pos == 0) begin
                m_hdr = b;
                m_pos = 1;
            end else if (m_pos == 1) begin
                m_n = int'({m_hdr, b});
                m_x = '0;
                if (m_n > int'(DEPTH)) m_err = 1;
                else m_pos = 2;
            end else if (m_pos < 2 + 2 * m_n) begin
                k = m_pos - 2;
                if (k % 2 == 0) begin
                    m_hi = b;
                end else begin
                    m_wr   = 1;
                    m_addr = 16'(k - 1);
                    m_data = {m_hi, b};
                end
                m_x = m_x ^ b;
                m_pos++;
            end else begin
                if (b == m_x) m_done = 1;
                else m_err = 1;
            end
        end else if (m_pos != 0) begin
            m_idle++;
            if (m_idle >= int'(TIMEOUT)) m_err = 1;
        end
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rx_ready", 32'(bus.rx_ready), 32'(m_live && !(m_done || m_err || m_wr)));
                check("pm_wr_en", 32'(bus.pm_wr_en), 32'(m_wr));
                if (m_wr) begin
                    check("pm_wr_addr", 32'(bus.pm_wr_addr), 32'(m_addr));
                    check("pm_wr_data", 32'(bus.pm_wr_data), 32'(m_data));
                end
                check("cpu_hold", 32'(bus.cpu_hold), 32'(!m_done));
                check("done", 32'(bus.done), 32'(m_done));
                check("error", 32'(bus.error), 32'(m_err));
                check("words_loaded", 32'(bus.words_loaded), 32'(m_wl));
                if (bus.pm_wr_en) wr_log.push_back({bus.pm_wr_addr, bus.pm_wr_data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected to finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] log_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic idle(input int c);
        bus.rx_valid = 1'b0;
        repeat (c) begin
            bus.rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit   got;
        logic r;
        got = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            r = bus.rx_ready;
            @(posedge clk);
            #1;
            got = r;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_accept: byte 0x%0h got no transfer, expected one within 8 cycles", b);
        end
    endtask

    task automatic send_stream(input bit gaps, input int long_at);
        for (int i = 0; i < byte_q.size(); i++) begin
            if (m_done || m_err) break;
            if (i == long_at) idle(int'(TIMEOUT) + 5);
            if (m_done || m_err) break;
            if (gaps) idle(int'($urandom_range(0, 3)));
            send_byte(byte_q[i]);
        end
    endtask

    task automatic build_frame(input int n, input logic [7:0] corrupt);
        logic [7:0] x, b;
        int         nd;
        byte_q.delete();
        byte_q.push_back(8'(n >> 8));
        byte_q.push_back(8'(n));
        x  = '0;
        nd = (n > int'(DEPTH)) ? 2 : n;
        for (int i = 0; i < 2 * nd; i++) begin
            b = 8'($urandom);
            byte_q.push_back(b);
            x = x ^ b;
        end
        byte_q.push_back(x ^ corrupt);
    endtask

    // Async reset mid-cycle; outputs must change before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        check("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
        check("rst_pm_wr_en", 32'(bus.pm_wr_en), 32'h0);
        check("rst_pm_wr_addr", 32'(bus.pm_wr_addr), 32'h0);
        check("rst_pm_wr_data", 32'(bus.pm_wr_data), 32'h0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'h1);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_error", 32'(bus.error), 32'h0);
        check("rst_words_loaded", 32'(bus.words_loaded), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr_log.delete();
    endtask

    initial begin
        int         n, long_at;
        logic [7:0] corrupt;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;

        // Two-word frame, good checksum; then stray bytes after DONE.
        do_reset();
        byte_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_stream(1'b0, -1);
        idle(3);
        check("t1_nwrites", 32'(wr_log.size()), 32'd2);
        check("t1_write0", log_at(0), 32'h0000_1234);
        check("t1_write1", log_at(1), 32'h0002_ABCD);
        check("t1_done", 32'(bus.done), 32'h1);
        check("t1_cpu_hold", 32'(bus.cpu_hold), 32'h0);
        check("t1_error", 32'(bus.error), 32'h0);
        check("t1_words", 32'(bus.words_loaded), 32'd2);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        idle(0);
        repeat (4) begin @(posedge clk); #1; end
        idle(2);
        check("t1_sticky_done", 32'(bus.done), 32'h1);
        check("t1_sticky_nwrites", 32'(wr_log.size()), 32'd2);

        // Same frame, bad checksum.
        do_reset();
        byte_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_stream(1'b1, -1);
        idle(3);
        check("t2_nwrites", 32'(wr_log.size()), 32'd2);
        check("t2_error", 32'(bus.error), 32'h1);
        check("t2_cpu_hold", 32'(bus.cpu_hold), 32'h1);
        check("t2_done", 32'(bus.done), 32'h0);

        // Count one above capacity.
        do_reset();
        byte_q = '{8'h01, 8'h01, 8'h11, 8'h22};
        send_stream(1'b0, -1);
        idle(3);
        check("t3_error", 32'(bus.error), 32'h1);
        check("t3_nwrites", 32'(wr_log.size()), 32'd0);
        check("t3_rx_ready", 32'(bus.rx_ready), 32'h0);

        // Count exactly at capacity.
        do_reset();
        build_frame(int'(DEPTH), 8'h00);
        send_stream(1'b0, -1);
        idle(3);
        check("t3b_done", 32'(bus.done), 32'h1);
        check("t3b_words", 32'(bus.words_loaded), 32'd256);
        check("t3b_last_addr", 32'(log_at(255) >> 16), 32'h0000_01FE);

        // Empty image.
        do_reset();
        byte_q = '{8'h00, 8'h00, 8'h00};
        send_stream(1'b0, -1);
        idle(3);
        check("t4_done", 32'(bus.done), 32'h1);
        check("t4_words", 32'(bus.words_loaded), 32'd0);
        do_reset();
        byte_q = '{8'h00, 8'h00, 8'h01};
        send_stream(1'b0, -1);
        idle(3);
        check("t4b_error", 32'(bus.error), 32'h1);
        check("t4b_done", 32'(bus.done), 32'h0);

        // Stall after the first data byte.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h55);
        idle(int'(TIMEOUT) - 1);
        check("t5_error_before", 32'(bus.error), 32'h0);
        idle(1);
        check("t5_error_at", 32'(bus.error), 32'h1);
        check("t5_nwrites", 32'(wr_log.size()), 32'd0);

        // Reset during DATA_LO of word 3 of 5, then a clean reload.
        do_reset();
        build_frame(5, 8'h00);
        for (int i = 0; i < 7; i++) send_byte(byte_q[i]);
        idle(1);
        do_reset();
        build_frame(5, 8'h00);
        send_stream(1'b1, -1);
        idle(3);
        check("t6_done", 32'(bus.done), 32'h1);
        check("t6_nwrites", 32'(wr_log.size()), 32'd5);
        check("t6_first_addr", 32'(log_at(0) >> 16), 32'h0);

        // Randomized frames: sizes, checksum corruption, gaps and stalls.
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 9))
                0:       n = int'($urandom_range(257, 65535));
                1:       n = 0;
                default: n = int'($urandom_range(1, 6));
            endcase
            corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            do_reset();
            build_frame(n, corrupt);
            long_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, byte_q.size() - 1)) : -1;
            send_stream(1'b1, long_at);
            idle(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
